// File: rtl/pc_update_if.sv
// Bundles the fetch-stage stall/redirect inputs and the registered PC outputs
// so that the PC unit and its driver share one connection.
interface pc_update_if #(
  parameter int PC_WIDTH     = 32,
  parameter int OFFSET_WIDTH = 8,
  parameter int COUNT_WIDTH  = 16
);
  logic                    busywait;
  logic                    flow_select;
  logic [OFFSET_WIDTH-1:0] offset;
  logic [PC_WIDTH-1:0]     pc;
  logic                    pc_valid;
  logic                    stalled;
  logic [COUNT_WIDTH-1:0]  retired;

  // Driver side: control-flow logic and memory stall source
  modport master (
    output busywait, flow_select, offset,
    input  pc, pc_valid, stalled, retired
  );

  // PC unit side
  modport slave (
    input  busywait, flow_select, offset,
    output pc, pc_valid, stalled, retired
  );
endinterface

// File: rtl/pc_update_unit.sv
// Registered program-counter stage: picks PC+4 or PC+4+offset*4, commits it on
// each advancing edge, holds while memory stalls, and counts retired advances.
module pc_update_unit #(
  parameter int PC_WIDTH     = 32,
  parameter int OFFSET_WIDTH = 8,
  parameter int COUNT_WIDTH  = 16
) (
  input logic           CLK,
  input logic           RESET,
  pc_update_if.slave    bus
);

  localparam logic [1:0] ST_RST  = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  logic [1:0]             state_reg;
  logic [PC_WIDTH-1:0]    pc_reg;
  logic                   pc_valid_reg;
  logic                   stalled_reg;
  logic [COUNT_WIDTH-1:0] retired_reg;

  logic [PC_WIDTH-1:0]    seq_addr;
  logic [PC_WIDTH-1:0]    offset_ext;
  logic [PC_WIDTH-1:0]    target_addr;
  logic [PC_WIDTH-1:0]    pc_next;
  logic [COUNT_WIDTH-1:0] retired_next;

  // Next-address datapath; all sums wrap silently modulo 2^PC_WIDTH
  always_comb begin
    seq_addr     = pc_reg + PC_WIDTH'(4);
    offset_ext   = {{(PC_WIDTH-OFFSET_WIDTH-2){bus.offset[OFFSET_WIDTH-1]}},
                    bus.offset, 2'b00};
    target_addr  = seq_addr + offset_ext;
    pc_next      = bus.flow_select ? target_addr : seq_addr;
    // Counter sticks at all-ones instead of wrapping
    retired_next = (&retired_reg) ? retired_reg : retired_reg + COUNT_WIDTH'(1);
  end

  // Control FSM and registered outputs; a stalled edge leaves PC untouched so
  // the redirect is re-evaluated from stable inputs on the releasing edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= ST_RST;
      pc_reg       <= '0;
      pc_valid_reg <= 1'b0;
      stalled_reg  <= 1'b0;
      retired_reg  <= '0;
    end else begin
      case (state_reg)
        ST_RST: begin
          // First edge out of reset only announces address 0 as valid
          state_reg    <= ST_RUN;
          pc_valid_reg <= 1'b1;
        end
        ST_RUN: begin
          if (bus.busywait) begin
            state_reg   <= ST_HOLD;
            stalled_reg <= 1'b1;
          end else begin
            pc_reg      <= pc_next;
            retired_reg <= retired_next;
          end
        end
        ST_HOLD: begin
          if (!bus.busywait) begin
            pc_reg      <= pc_next;
            retired_reg <= retired_next;
            stalled_reg <= 1'b0;
            state_reg   <= ST_RUN;
          end
        end
        default: begin
          state_reg    <= ST_RST;
          pc_reg       <= '0;
          pc_valid_reg <= 1'b0;
          stalled_reg  <= 1'b0;
          retired_reg  <= '0;
        end
      endcase
    end
  end

  assign bus.pc       = pc_reg;
  assign bus.pc_valid = pc_valid_reg;
  assign bus.stalled  = stalled_reg;
  assign bus.retired  = retired_reg;

endmodule

// File: tb/tb_pc_update_unit.sv
// Scoreboard bench for pc_update_unit: two instances (16-bit and 4-bit retired
// counters) share one stimulus stream; a reference model pushes the expected
// post-edge outputs and a monitor pops and compares after every rising edge.
module tb_pc_update_unit;

  logic clk;
  logic rst;

  pc_update_if #(.PC_WIDTH(32), .OFFSET_WIDTH(8), .COUNT_WIDTH(16)) bus ();
  pc_update_if #(.PC_WIDTH(32), .OFFSET_WIDTH(8), .COUNT_WIDTH(4))  bus4 ();

  pc_update_unit #(.PC_WIDTH(32), .OFFSET_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .CLK(clk), .RESET(rst), .bus(bus)
  );
  pc_update_unit #(.PC_WIDTH(32), .OFFSET_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
    .CLK(clk), .RESET(rst), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        stalled;
    logic [15:0] ret;
    logic [3:0]  ret4;
    bit          lit_en;
    logic [31:0] lit_pc;
    bit          r4_en;
    logic [3:0]  r4_lit;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;
  bit   stim_done = 0;

  // Reference model state (behavioural, derived from the rules of the stage)
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_stalled;
  int          m_ret;
  int          m_ret4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s txn=%0d actual=0x%08h required=0x%08h", name, txn, act, req);
    end
  endtask

  // Apply one cycle of inputs and predict the outputs after the next edge
  task automatic step(input bit r, input bit b, input bit f, input logic [7:0] o,
                      input bit lit_en = 0, input logic [31:0] lit_pc = 0,
                      input bit r4_en = 0, input logic [3:0] r4_lit = 0);
    exp_t e;
    int   so;
    @(negedge clk);
    rst = r;
    bus.busywait = b;  bus.flow_select = f;  bus.offset = o;
    bus4.busywait = b; bus4.flow_select = f; bus4.offset = o;
    if (r) begin
      m_pc = 0; m_valid = 0; m_stalled = 0; m_ret = 0; m_ret4 = 0;
    end else if (!m_valid) begin
      m_valid = 1;
    end else if (b) begin
      m_stalled = 1;
    end else begin
      so = int'($signed(o));
      m_pc = m_pc + 32'd4 + (f ? 32'(so * 4) : 32'd0);
      m_ret  = (m_ret  < 65535) ? m_ret + 1  : m_ret;
      m_ret4 = (m_ret4 < 15)    ? m_ret4 + 1 : m_ret4;
      m_stalled = 0;
    end
    e.pc = m_pc; e.valid = m_valid; e.stalled = m_stalled;
    e.ret = 16'(m_ret); e.ret4 = 4'(m_ret4);
    e.lit_en = lit_en; e.lit_pc = lit_pc; e.r4_en = r4_en; e.r4_lit = r4_lit;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction after each edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      txn++;
      chk("pc",       bus.pc,                 e.pc);
      chk("pc_valid", {31'd0, bus.pc_valid},  {31'd0, e.valid});
      chk("stalled",  {31'd0, bus.stalled},   {31'd0, e.stalled});
      chk("retired",  {16'd0, bus.retired},   {16'd0, e.ret});
      chk("pc_w4",    bus4.pc,                e.pc);
      chk("retired4", {28'd0, bus4.retired},  {28'd0, e.ret4});
      if (e.lit_en) chk("pc_plan", bus.pc, e.lit_pc);
      if (e.r4_en)  chk("ret4_sat", {28'd0, bus4.retired}, {28'd0, e.r4_lit});
      $display("txn %0d: pc=0x%08h valid=%0b stalled=%0b retired=%0d retired4=%0d",
               txn, bus.pc, bus.pc_valid, bus.stalled, bus.retired, bus4.retired);
    end
  end

  initial begin
    rst = 1'b1;
    bus.busywait = 0;  bus.flow_select = 0;  bus.offset = 0;
    bus4.busywait = 0; bus4.flow_select = 0; bus4.offset = 0;
    m_pc = 0; m_valid = 0; m_stalled = 0; m_ret = 0; m_ret4 = 0;

    // Reset and sequential fetch
    step(1, 0, 0, 8'h00, 1, 32'h0);
    step(1, 0, 0, 8'h00, 1, 32'h0);
    step(0, 0, 0, 8'h00, 1, 32'h0);
    step(0, 0, 0, 8'h00, 1, 32'h4);
    step(0, 0, 0, 8'h00, 1, 32'h8);
    step(0, 0, 0, 8'h00, 1, 32'hC);
    step(0, 0, 0, 8'h00, 1, 32'h10);
    // Forward, backward and self-loop branches
    step(0, 0, 1, 8'h02, 1, 32'h1C);
    step(0, 0, 1, 8'hFE, 1, 32'h18);
    step(0, 0, 1, 8'hFF, 1, 32'h18);
    step(0, 0, 0, 8'h00, 1, 32'h1C);
    step(0, 0, 0, 8'h00, 1, 32'h20);
    // Stall with toggling redirect inputs, then release sequentially
    step(0, 1, 1, 8'h10, 1, 32'h20);
    step(0, 1, 0, 8'h44, 1, 32'h20);
    step(0, 1, 1, 8'h33, 1, 32'h20);
    step(0, 0, 0, 8'h00, 1, 32'h24);
    // Wrap-around in both directions
    step(0, 0, 1, 8'hF5, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 8'h00, 1, 32'h0);
    step(0, 0, 1, 8'h80, 1, 32'hFFFF_FE04);
    // Reset mid-stall at 0x40
    step(1, 0, 0, 8'h00, 1, 32'h0);
    step(0, 0, 0, 8'h00, 1, 32'h0);
    step(0, 0, 0, 8'h00, 1, 32'h4);
    step(0, 0, 0, 8'h00, 1, 32'h8);
    step(0, 0, 0, 8'h00, 1, 32'hC);
    step(0, 0, 0, 8'h00, 1, 32'h10);
    step(0, 0, 1, 8'h0B, 1, 32'h40);
    step(0, 1, 0, 8'h00, 1, 32'h40);
    step(0, 1, 0, 8'h00, 1, 32'h40);
    step(1, 1, 1, 8'h22, 1, 32'h0);
    // Counter saturation on the 4-bit instance
    step(0, 0, 0, 8'h00, 1, 32'h0);
    for (int i = 0; i < 20; i++)
      step(0, 0, 0, 8'h00, 0, 32'h0, (i == 19), 4'hF);
    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
           $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
    stim_done = 1;
  end

  // Drain the scoreboard with a bounded wait, then summarize
  initial begin
    wait (stim_done);
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
